// File: rtl/ahb_crc_slave.sv
// AHB-Lite slave with a bit-serial, MSB-first, non-reflected CRC-32 engine.
// Define CRC_ERR_RESP_EN to enable two-cycle ERROR responses for bad accesses.
module ahb_crc_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] POLY_RESET = 32'h04C11DB7,
    parameter logic [31:0] INIT_RESET = 32'hFFFFFFFF
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  CRC_IRQ
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegPoly   = 3'd1;
    localparam logic [2:0] RegInit   = 3'd2;
    localparam logic [2:0] RegData   = 3'd3;
    localparam logic [2:0] RegResult = 3'd4;
    localparam logic [2:0] RegStatus = 3'd5;

    // Data-phase capture of the accepted address phase
    logic       dp_valid_q, dp_valid_d;
    logic [4:0] dp_addr_q, dp_addr_d;
    logic       dp_write_q, dp_write_d;
    logic [2:0] dp_size_q, dp_size_d;

    // Engine and register state
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] poly_q, poly_d;
    logic [31:0] init_q, init_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;

    logic [2:0]  sel;
    logic        busy;
    logic        err;
    logic        stall_sel;
    logic        stall;
    logic        hready_int;
    logic        xfer_done;
    logic        wr_en;
    logic        done_set;
    logic        fb;
    logic [5:0]  nbits;
    logic [31:0] aligned;

    logic unused_bits;
    assign unused_bits = ^{HBURST, HADDR[ADDR_WIDTH-1:5]};

    assign sel  = dp_addr_q[4:2];
    assign busy = (state_q == StShift);

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_addr_d  = dp_addr_q;
        dp_write_d = dp_write_q;
        dp_size_d  = dp_size_q;
        if (HREADY) begin
            dp_valid_d = HSEL & HTRANS[1];
            dp_addr_d  = HADDR[4:0];
            dp_write_d = HWRITE;
            dp_size_d  = HSIZE;
        end
    end

    always_comb begin
        err = 1'b0;
        if (dp_valid_q) begin
            if (sel > RegStatus) err = 1'b1;
            if (dp_size_q > 3'b010) err = 1'b1;
            if (dp_size_q == 3'b001 && dp_addr_q[0]) err = 1'b1;
            if (dp_size_q == 3'b010 && dp_addr_q[1:0] != 2'b00) err = 1'b1;
            if (dp_write_q && sel == RegResult) err = 1'b1;
        end
    end

    // Only accesses that depend on or disturb the running CRC wait for the engine
    assign stall_sel = dp_write_q ? (sel <= RegData) : (sel == RegResult);
    assign stall     = dp_valid_q & ~err & busy & stall_sel;

`ifdef CRC_ERR_RESP_EN
    logic err_second_q;
    logic err_second_d;

    assign err_second_d = err & ~err_second_q;
    assign hready_int   = ~stall & ~(err & ~err_second_q);
    assign HRESP        = err;

    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            err_second_q <= 1'b0;
        end else begin
            err_second_q <= err_second_d;
        end
    end
`else
    assign hready_int = ~stall;
    assign HRESP      = 1'b0;
`endif

    assign HREADYOUT = hready_int;
    assign xfer_done = dp_valid_q & hready_int & ~err;
    assign wr_en     = xfer_done & dp_write_q;
    assign CRC_IRQ   = done_q & ie_q;

    // Left-justify the selected byte lanes so the engine always shifts from bit 31
    always_comb begin
        nbits   = 6'd32;
        aligned = HWDATA;
        case (dp_size_q)
            3'b000: begin
                nbits   = 6'd8;
                aligned = {HWDATA[8*dp_addr_q[1:0] +: 8], 24'h000000};
            end
            3'b001: begin
                nbits   = 6'd16;
                aligned = {HWDATA[16*dp_addr_q[1] +: 16], 16'h0000};
            end
            default: begin
                nbits   = 6'd32;
                aligned = HWDATA;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        crc_d    = crc_q;
        done_set = 1'b0;
        fb       = crc_q[31] ^ sh_q[31];
        case (state_q)
            StIdle: begin
                if (wr_en && sel == RegData) begin
                    sh_d    = aligned;
                    cnt_d   = nbits;
                    state_d = StShift;
                end else if (wr_en && sel == RegCtrl && HWDATA[1]) begin
                    crc_d = init_q;
                end
            end
            StShift: begin
                crc_d = {crc_q[30:0], 1'b0} ^ (fb ? poly_q : 32'h0);
                sh_d  = {sh_q[30:0], 1'b0};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ie_d   = ie_q;
        poly_d = poly_q;
        init_d = init_q;
        done_d = done_q;
        if (wr_en) begin
            case (sel)
                RegCtrl:   ie_d   = HWDATA[0];
                RegPoly:   poly_d = HWDATA;
                RegInit:   init_d = HWDATA;
                RegStatus: if (HWDATA[1]) done_d = 1'b0;
                default:   ;
            endcase
        end
        // A completing shift beats a simultaneous write-1-to-clear
        if (done_set) done_d = 1'b1;
    end

    always_comb begin
        HRDATA = 32'h0;
        if (dp_valid_q && !dp_write_q && !err) begin
            case (sel)
                RegCtrl:   HRDATA = {31'h0, ie_q};
                RegPoly:   HRDATA = poly_q;
                RegInit:   HRDATA = init_q;
                RegResult: HRDATA = crc_q;
                RegStatus: HRDATA = {30'h0, done_q, busy};
                default:   HRDATA = 32'h0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            dp_valid_q <= 1'b0;
            dp_addr_q  <= 5'h00;
            dp_write_q <= 1'b0;
            dp_size_q  <= 3'b000;
            state_q    <= StIdle;
            cnt_q      <= 6'd0;
            sh_q       <= 32'h0;
            crc_q      <= INIT_RESET;
            poly_q     <= POLY_RESET;
            init_q     <= INIT_RESET;
            ie_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_addr_q  <= dp_addr_d;
            dp_write_q <= dp_write_d;
            dp_size_q  <= dp_size_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            crc_q      <= crc_d;
            poly_q     <= poly_d;
            init_q     <= init_d;
            ie_q       <= ie_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ahb_crc_slave.sv
// Self-checking bench for ahb_crc_slave: directed cases plus randomized CRC sequences.
// Expected CRCs come from a byte/word-level division model.
module tb_ahb_crc_slave;

    logic        HCLK;
    logic        RESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        CRC_IRQ;

    assign HREADY = HREADYOUT;

    ahb_crc_slave dut (
        .HCLK      (HCLK),
        .RESET     (RESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .CRC_IRQ   (CRC_IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  sq_addr  [16];
    logic [2:0]  sq_size  [16];
    logic        sq_wr    [16];
    logic [31:0] sq_wdata [16];
    logic [31:0] sq_rdata [16];
    int          sq_waits [16];
    logic        sq_err   [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    endtask

    task automatic set_item(input int i, input logic [4:0] a, input logic [2:0] sz,
                            input logic wr, input logic [31:0] wd);
        sq_addr[i]  = a;
        sq_size[i]  = sz;
        sq_wr[i]    = wr;
        sq_wdata[i] = wd;
    endtask

    task automatic drive_addr(input int i);
        HSEL   = 1'b1;
        HADDR  = {8'h40, 19'h0, sq_addr[i]};
        HTRANS = 2'b10;
        HWRITE = sq_wr[i];
        HSIZE  = sq_size[i];
        HBURST = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Fully pipelined: address phase of item k+1 overlaps the data phase of item k
    task automatic run_seq(input int n);
        @(negedge HCLK);
        drive_addr(0);
        for (int k = 0; k < n; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            HWDATA = sq_wdata[k];
            if (k + 1 < n) drive_addr(k + 1);
            else drive_idle();
            sq_waits[k] = 0;
            sq_err[k]   = 1'b0;
            while (HREADYOUT !== 1'b1) begin
                sq_err[k] = sq_err[k] | HRESP;
                sq_waits[k]++;
                if (sq_waits[k] > 300) begin
                    check_eq("timeout_waits", sq_waits[k], 300);
                    finish_now();
                end
                @(posedge HCLK);
                @(negedge HCLK);
            end
            sq_err[k]   = sq_err[k] | HRESP;
            sq_rdata[k] = HRDATA;
        end
        @(posedge HCLK);
    endtask

    task automatic rd1(input logic [4:0] a, output logic [31:0] d);
        set_item(0, a, 3'b010, 1'b0, 32'h0);
        run_seq(1);
        d = sq_rdata[0];
    endtask

    // Polynomial long division, one message chunk at a time
    function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] poly,
                                            input logic [31:0] val, input int n);
        logic [31:0] c;
        c = crc ^ (val << (32 - n));
        for (int i = 0; i < n; i++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        return c;
    endfunction

    task automatic set_data(input int i, input int sz, output int nb, output logic [31:0] v);
        logic [31:0] w;
        int          a;
        w = $urandom;
        a = $urandom_range(0, 3);
        if (sz == 0) begin
            set_item(i, 5'h0C | 5'(a), 3'b000, 1'b1, w);
            nb = 8;
            v  = (w >> (8 * a)) & 32'hFF;
        end else if (sz == 1) begin
            set_item(i, 5'h0C | 5'(a & 2), 3'b001, 1'b1, w);
            nb = 16;
            v  = (w >> (8 * (a & 2))) & 32'hFFFF;
        end else begin
            set_item(i, 5'h0C, 3'b010, 1'b1, w);
            nb = 32;
            v  = w;
        end
    endtask

    logic [31:0] rd;
    logic [31:0] m_crc, m_poly, m_init, v1, v2;
    int          n1, n2, j;
    logic        reinit;

    initial begin
        RESET  = 1'b0;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HBURST = 3'b000;
        HWDATA = 32'h0;

        // Reset state
        repeat (3) @(negedge HCLK);
        check_eq("rst_hreadyout", HREADYOUT, 1);
        check_eq("rst_hresp", HRESP, 0);
        check_eq("rst_irq", CRC_IRQ, 0);
        check_eq("rst_hrdata", HRDATA, 0);
        RESET = 1'b1;
        rd1(5'h04, rd); check_eq("rst_poly", rd, 32'h04C11DB7);
        rd1(5'h08, rd); check_eq("rst_init", rd, 32'hFFFFFFFF);
        rd1(5'h10, rd); check_eq("rst_result", rd, 32'hFFFFFFFF);
        rd1(5'h14, rd); check_eq("rst_status", rd, 32'h0);
        rd1(5'h00, rd); check_eq("rst_ctrl", rd, 32'h0);

        // Nine back-to-back bytes "123456789"
        for (int i = 0; i < 9; i++) set_item(i, 5'h0C, 3'b000, 1'b1, {24'hA5A5A5, 8'(8'h31 + i)});
        set_item(9, 5'h10, 3'b010, 1'b0, 32'h0);
        set_item(10, 5'h14, 3'b010, 1'b0, 32'h0);
        run_seq(11);
        check_eq("b9_first_waits", sq_waits[0], 0);
        for (int i = 1; i < 9; i++) check_eq("b9_byte_waits", sq_waits[i], 8);
        check_eq("b9_result_waits", sq_waits[9], 8);
        check_eq("b9_result", sq_rdata[9], 32'h0376E6E7);
        check_eq("b9_status", sq_rdata[10], 32'h2);
        check_eq("b9_hresp", sq_err[9], 0);

        // Two words and a byte back-to-back after re-init
        set_item(0, 5'h00, 3'b010, 1'b1, 32'h2);
        set_item(1, 5'h0C, 3'b010, 1'b1, 32'h31323334);
        set_item(2, 5'h0C, 3'b010, 1'b1, 32'h35363738);
        set_item(3, 5'h0C, 3'b000, 1'b1, 32'h00000039);
        set_item(4, 5'h10, 3'b010, 1'b0, 32'h0);
        run_seq(5);
        check_eq("w2_ctrl_waits", sq_waits[0], 0);
        check_eq("w2_word0_waits", sq_waits[1], 0);
        check_eq("w2_word1_waits", sq_waits[2], 32);
        check_eq("w2_byte_waits", sq_waits[3], 32);
        check_eq("w2_result_waits", sq_waits[4], 8);
        check_eq("w2_result", sq_rdata[4], 32'h0376E6E7);

        // Interrupt timing on a halfword with INIT=0
        set_item(0, 5'h14, 3'b010, 1'b1, 32'h2);
        set_item(1, 5'h08, 3'b010, 1'b1, 32'h0);
        set_item(2, 5'h00, 3'b010, 1'b1, 32'h3);
        set_item(3, 5'h0C, 3'b001, 1'b1, 32'hBEEF0001);
        run_seq(4);
        check_eq("irq_half_waits", sq_waits[3], 0);
        j = 1;
        forever begin
            @(negedge HCLK);
            if (CRC_IRQ === 1'b1 || j > 100) break;
            j++;
            @(posedge HCLK);
        end
        check_eq("irq_delay", j, 17);
        rd1(5'h10, rd); check_eq("irq_result", rd, 32'h04C11DB7);
        rd1(5'h00, rd); check_eq("irq_ctrl_rd", rd, 32'h1);
        set_item(0, 5'h14, 3'b010, 1'b1, 32'h2);
        run_seq(1);
        @(negedge HCLK);
        check_eq("irq_cleared", CRC_IRQ, 0);
        rd1(5'h14, rd); check_eq("irq_status_clr", rd, 32'h0);

        // DONE set and write-1-clear in the same cycle
        set_item(0, 5'h0C, 3'b000, 1'b1, 32'hA5);
        for (int i = 1; i < 8; i++) set_item(i, 5'h14, 3'b010, 1'b0, 32'h0);
        set_item(8, 5'h14, 3'b010, 1'b1, 32'h2);
        set_item(9, 5'h14, 3'b010, 1'b0, 32'h0);
        run_seq(10);
        for (int i = 1; i < 8; i++) check_eq("sw_busy_status", sq_rdata[i], 32'h1);
        check_eq("sw_wr_waits", sq_waits[8], 0);
        check_eq("sw_set_wins", sq_rdata[9], 32'h2);

        // Randomized sequences against the division model
        for (int it = 0; it < 20; it++) begin
            m_init = $urandom;
            m_poly = $urandom | 32'h1;
            reinit = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            set_item(0, 5'h08, 3'b010, 1'b1, m_init);
            set_item(1, 5'h04, 3'b010, 1'b1, m_poly);
            set_item(2, 5'h00, 3'b010, 1'b1, {30'h0, reinit, 1'b0});
            set_data(3, $urandom_range(0, 2), n1, v1);
            set_data(4, $urandom_range(0, 2), n2, v2);
            set_item(5, 5'h10, 3'b010, 1'b0, 32'h0);
            set_item(6, 5'h14, 3'b010, 1'b0, 32'h0);
            run_seq(7);
            if (reinit) m_crc = m_init;
            m_crc = crc_ref(m_crc, m_poly, v1, n1);
            m_crc = crc_ref(m_crc, m_poly, v2, n2);
            check_eq("rnd_cfg_waits", sq_waits[2], 0);
            check_eq("rnd_data0_waits", sq_waits[3], 0);
            check_eq("rnd_data1_waits", sq_waits[4], n1);
            check_eq("rnd_result_waits", sq_waits[5], n2);
            check_eq("rnd_result", sq_rdata[5], m_crc);
            check_eq("rnd_status", sq_rdata[6], 32'h2);
        end

        // Reset in the middle of a word shift
        set_item(0, 5'h0C, 3'b010, 1'b1, 32'h12345678);
        run_seq(1);
        repeat (10) @(negedge HCLK);
        RESET = 1'b0;
        #1;
        check_eq("midrst_hreadyout", HREADYOUT, 1);
        @(negedge HCLK);
        RESET = 1'b1;
        rd1(5'h14, rd); check_eq("midrst_status", rd, 32'h0);
        rd1(5'h10, rd); check_eq("midrst_result", rd, 32'hFFFFFFFF);
        rd1(5'h04, rd); check_eq("midrst_poly", rd, 32'h04C11DB7);

        // Bad accesses
        set_item(0, 5'h18, 3'b010, 1'b0, 32'h0);
        set_item(1, 5'h14, 3'b010, 1'b0, 32'h0);
        run_seq(2);
`ifdef CRC_ERR_RESP_EN
        check_eq("err_unmapped_waits", sq_waits[0], 1);
        check_eq("err_unmapped_resp", sq_err[0], 1);
`else
        check_eq("err_unmapped_waits", sq_waits[0], 0);
        check_eq("err_unmapped_resp", sq_err[0], 0);
        check_eq("err_unmapped_rdata", sq_rdata[0], 32'h0);
`endif
        check_eq("err_next_resp", sq_err[1], 0);
        check_eq("err_next_status", sq_rdata[1], 32'h0);

        set_item(0, 5'h10, 3'b010, 1'b1, 32'h0);
        set_item(1, 5'h0E, 3'b010, 1'b1, 32'hDEADBEEF);
        set_item(2, 5'h04, 3'b011, 1'b1, 32'h0);
        set_item(3, 5'h10, 3'b010, 1'b0, 32'h0);
        set_item(4, 5'h14, 3'b010, 1'b0, 32'h0);
        set_item(5, 5'h04, 3'b010, 1'b0, 32'h0);
        run_seq(6);
`ifdef CRC_ERR_RESP_EN
        check_eq("err_wr_result_waits", sq_waits[0], 1);
        check_eq("err_misalign_resp", sq_err[1], 1);
        check_eq("err_size_resp", sq_err[2], 1);
`else
        check_eq("err_wr_result_waits", sq_waits[0], 0);
        check_eq("err_misalign_resp", sq_err[1], 0);
        check_eq("err_size_resp", sq_err[2], 0);
`endif
        check_eq("err_result_kept", sq_rdata[3], 32'hFFFFFFFF);
        check_eq("err_no_shift", sq_rdata[4], 32'h0);
        check_eq("err_poly_kept", sq_rdata[5], 32'h04C11DB7);

        finish_now();
    end

endmodule
